// File: rtl/board_renderer.sv
// Minesweeper board renderer: scans the tile grid one pixel per clock and emits
// registered plots (x, y, color, writeEn) to the 160x120 VGA adapter.
module board_renderer #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int TILE_W   = 19,
    parameter int TILE_H   = 14,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    localparam int N       = COLS * ROWS,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             go_tile,
    input  logic [IDX_W-1:0] tile_idx,
    input  logic             reveal_all,
    input  logic [N-1:0]     mineMap,
    input  logic [N-1:0]     flagMap,
    input  logic [N-1:0]     stepMap,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       color,
    output logic             writeEn,
    output logic             busy,
    output logic             done
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int PY_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] tile_q, tile_d, last_q, last_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PX_W-1:0]  px_q, px_d;
    logic [PY_W-1:0]  py_q, py_d;
    logic [N-1:0]     mine_q, flag_q, step_q;
    logic             reveal_q;
    logic             snap_en;
    logic [7:0]       x_q, x_n;
    logic [6:0]       y_q, y_n;
    logic [2:0]       color_q, color_n;
    logic             tile_mine, tile_flag, tile_step, on_grid;

    // NOTE: every variable gets a default first so no branch can infer a latch.
    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        last_d  = last_q;
        col_d   = col_q;
        row_d   = row_q;
        px_d    = px_q;
        py_d    = py_q;
        snap_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LATCH;
                    snap_en = 1'b1;
                    tile_d  = '0;
                    last_d  = IDX_W'(N - 1);
                    col_d   = '0;
                    row_d   = '0;
                    px_d    = '0;
                    py_d    = '0;
                end else if (go_tile && (32'(tile_idx) < N)) begin
                    state_d = S_LATCH;
                    snap_en = 1'b1;
                    tile_d  = tile_idx;
                    last_d  = tile_idx;
                    col_d   = COL_W'(32'(tile_idx) % COLS);
                    row_d   = ROW_W'(32'(tile_idx) / COLS);
                    px_d    = '0;
                    py_d    = '0;
                end
            end
            S_LATCH: state_d = S_DRAW;
            S_DRAW: begin
                if (px_q != PX_W'(TILE_W - 1)) begin
                    px_d = px_q + PX_W'(1);
                end else begin
                    px_d = '0;
                    if (py_q != PY_W'(TILE_H - 1)) begin
                        py_d = py_q + PY_W'(1);
                    end else begin
                        py_d = '0;
                        if (tile_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            tile_d = tile_q + IDX_W'(1);
                            if (col_q == COL_W'(COLS - 1)) begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Plot registers are loaded from the next pixel position, so in DRAW the
    // counters always describe the pixel currently on the outputs.
    assign tile_mine = mine_q[tile_d];
    assign tile_flag = flag_q[tile_d];
    assign tile_step = step_q[tile_d];
    assign on_grid   = (px_d == PX_W'(TILE_W - 1)) || (py_d == PY_W'(TILE_H - 1));
    assign x_n       = 8'(32'(ORIGIN_X) + 32'(col_d) * 32'(TILE_W) + 32'(px_d));
    assign y_n       = 7'(32'(ORIGIN_Y) + 32'(row_d) * 32'(TILE_H) + 32'(py_d));

    always_comb begin
        if (on_grid)                     color_n = 3'b000;
        else if (tile_step && tile_mine) color_n = 3'b100;
        else if (tile_step)              color_n = 3'b111;
        else if (tile_flag)              color_n = 3'b010;
        else if (reveal_q && tile_mine)  color_n = 3'b101;
        else                             color_n = 3'b001;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            tile_q   <= '0;
            last_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            mine_q   <= '0;
            flag_q   <= '0;
            step_q   <= '0;
            reveal_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            last_q  <= last_d;
            col_q   <= col_d;
            row_q   <= row_d;
            px_q    <= px_d;
            py_q    <= py_d;
            // Snapshot on request acceptance so the first pixel can leave LATCH registered.
            if (snap_en) begin
                mine_q   <= mineMap;
                flag_q   <= flagMap;
                step_q   <= stepMap;
                reveal_q <= reveal_all;
            end
            if (state_d == S_DRAW) begin
                x_q     <= x_n;
                y_q     <= y_n;
                color_q <= color_n;
            end
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign color   = color_q;
    assign writeEn = (state_q == S_DRAW);
    assign busy    = (state_q == S_LATCH) || (state_q == S_DRAW);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: default 8x8 board plus a 2x2 board of 3x2 tiles,
// compared against a nested-loop frame model built from the colour rules.
module tb_board_renderer;

    localparam int COLS = 8, TW = 19, TH = 14, N = 64;
    localparam int S_COLS = 2, S_TW = 3, S_TH = 2;

    logic        clk;
    logic        resetn;
    logic        go, go_tile, reveal_all;
    logic [5:0]  tile_idx;
    logic [63:0] mine_map, flag_map, step_map;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        write_en, busy, done;

    logic        s_go, s_go_tile, s_reveal;
    logic [1:0]  s_tile_idx;
    logic [3:0]  s_mine, s_flag, s_step;
    logic [7:0]  s_x;
    logic [6:0]  s_y;
    logic [2:0]  s_color;
    logic        s_we, s_busy, s_done;

    board_renderer dut (
        .clk(clk), .resetn(resetn), .go(go), .go_tile(go_tile), .tile_idx(tile_idx),
        .reveal_all(reveal_all), .mineMap(mine_map), .flagMap(flag_map), .stepMap(step_map),
        .x(x), .y(y), .color(color), .writeEn(write_en), .busy(busy), .done(done)
    );

    board_renderer #(.COLS(S_COLS), .ROWS(2), .TILE_W(S_TW), .TILE_H(S_TH)) dut_s (
        .clk(clk), .resetn(resetn), .go(s_go), .go_tile(s_go_tile), .tile_idx(s_tile_idx),
        .reveal_all(s_reveal), .mineMap(s_mine), .flagMap(s_flag), .stepMap(s_step),
        .x(s_x), .y(s_y), .color(s_color), .writeEn(s_we), .busy(s_busy), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } plot_t;

    plot_t cap_q[$];
    plot_t exp_q[$];
    int    img[256][128];
    int    done_at;
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic int ref_color(int px, int py, int tw, int th, bit m, bit f, bit s, bit rv);
        if (px == tw - 1 || py == th - 1) return 0;
        if (s && m) return 4;
        if (s) return 7;
        if (f) return 2;
        if (rv && m) return 5;
        return 1;
    endfunction

    task automatic build_expected(int cols, int tw, int th, int first, int last,
                                  logic [63:0] m, logic [63:0] f, logic [63:0] s, logic rv);
        plot_t p;
        exp_q.delete();
        for (int t = first; t <= last; t++)
            for (int py = 0; py < th; py++)
                for (int px = 0; px < tw; px++) begin
                    p.x = ((t % cols) * tw + px) % 256;
                    p.y = ((t / cols) * th + py) % 128;
                    p.c = ref_color(px, py, tw, th, m[t], f[t], s[t], rv);
                    exp_q.push_back(p);
                end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i].x != exp_q[i].x || cap_q[i].y != exp_q[i].y || cap_q[i].c != exp_q[i].c)
                return i;
        return -1;
    endfunction

    task automatic request(bit g, bit gt, int idx);
        @(posedge clk); #1;
        go = g; go_tile = gt; tile_idx = 6'(idx);
        @(posedge clk); #1;
        go = 1'b0; go_tile = 1'b0;
    endtask

    // Cycle c = number of falling edges seen since the request was sampled.
    task automatic capture(int budget);
        plot_t p;
        cap_q.delete();
        done_at = -1;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 128; j++) img[i][j] = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (write_en) begin
                p.x = int'(x); p.y = int'(y); p.c = int'(color);
                cap_q.push_back(p);
                img[x][y] = int'(color);
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
    endtask

    task automatic rand_maps();
        mine_map = {$urandom(), $urandom()};
        flag_map = {$urandom(), $urandom()};
        step_map = {$urandom(), $urandom()};
        reveal_all = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        go = 0; go_tile = 0; tile_idx = 0; reveal_all = 0;
        mine_map = 0; flag_map = 0; step_map = 0;
        s_go = 0; s_go_tile = 0; s_tile_idx = 0; s_reveal = 0;
        s_mine = 0; s_flag = 0; s_step = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({x, y, color, write_en, busy, done} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d we=%b busy=%b done=%b, required all 0",
                     x, y, color, write_en, busy, done);
        end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_small_full();
        plot_t p;
        build_expected(S_COLS, S_TW, S_TH, 0, 3, 64'd0, 64'd0, 64'd0, 1'b0);
        cap_q.delete();
        done_at = -1;
        @(posedge clk); #1 s_go = 1'b1;
        @(posedge clk); #1 s_go = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (s_we) begin
                p.x = int'(s_x); p.y = int'(s_y); p.c = int'(s_color);
                cap_q.push_back(p);
            end
            if (s_done) begin
                done_at = c;
                break;
            end
        end
        n_cmp++;
        if (cap_q.size() !== 24) begin
            n_bad++; $display("FAIL small_plots: got %0d, required 24", cap_q.size());
        end
        n_cmp++;
        if (done_at !== 26) begin
            n_bad++; $display("FAIL small_done_cycle: got %0d, required 26", done_at);
        end
        n_cmp++;
        if (first_diff() !== -1) begin
            n_bad++;
            $display("FAIL small_pixels: plot %0d got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", first_diff(),
                     cap_q[first_diff()].x, cap_q[first_diff()].y, cap_q[first_diff()].c,
                     exp_q[first_diff()].x, exp_q[first_diff()].y, exp_q[first_diff()].c);
        end
        n_cmp++;
        if (cap_q.size() < 7 || cap_q[6].x !== 3 || cap_q[6].y !== 0) begin
            n_bad++;
            $display("FAIL small_tile1_start: got plot 6 at (%0d,%0d), required (3,0)",
                     cap_q.size() > 6 ? cap_q[6].x : -1, cap_q.size() > 6 ? cap_q[6].y : -1);
        end
        @(negedge clk);
        n_cmp++;
        if (s_done !== 1'b0) begin
            n_bad++; $display("FAIL small_done_pulse: done still %b one cycle later, required 0", s_done);
        end
    endtask

    task automatic test_flag_full();
        mine_map = 0; flag_map = 0; step_map = 0; reveal_all = 0;
        flag_map[9] = 1'b1;
        build_expected(COLS, TW, TH, 0, N - 1, mine_map, flag_map, step_map, reveal_all);
        request(1, 0, 0);
        capture(20000);
        n_cmp++;
        if (cap_q.size() !== 17024) begin
            n_bad++; $display("FAIL flag_plots: got %0d, required 17024", cap_q.size());
        end
        n_cmp++;
        if (done_at !== 17026) begin
            n_bad++; $display("FAIL flag_done_cycle: got %0d, required 17026", done_at);
        end
        n_cmp++;
        if (first_diff() !== -1) begin
            n_bad++;
            $display("FAIL flag_pixels: plot %0d got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", first_diff(),
                     cap_q[first_diff()].x, cap_q[first_diff()].y, cap_q[first_diff()].c,
                     exp_q[first_diff()].x, exp_q[first_diff()].y, exp_q[first_diff()].c);
        end
        n_cmp++;
        if (img[19][14] !== 2 || img[37][14] !== 0 || img[19][27] !== 0) begin
            n_bad++;
            $display("FAIL flag_tile9: got (19,14)=%0d (37,14)=%0d (19,27)=%0d, required 2 0 0",
                     img[19][14], img[37][14], img[19][27]);
        end
    endtask

    task automatic test_single_tile();
        mine_map = 0; flag_map = 0; step_map = 0; reveal_all = 0;
        step_map[0] = 1'b1; mine_map[0] = 1'b1;
        build_expected(COLS, TW, TH, 0, 0, mine_map, flag_map, step_map, reveal_all);
        request(0, 1, 0);
        capture(1000);
        n_cmp++;
        if (cap_q.size() !== 266 || done_at !== 268) begin
            n_bad++;
            $display("FAIL single0_count: got %0d plots done at %0d, required 266 plots done at 268",
                     cap_q.size(), done_at);
        end
        n_cmp++;
        if (first_diff() !== -1 || img[5][5] !== 4 || img[19][0] !== -1) begin
            n_bad++;
            $display("FAIL single0_pixels: got first diff %0d, (5,5)=%0d, (19,0)=%0d, required -1 4 -1",
                     first_diff(), img[5][5], img[19][0]);
        end
        step_map[1] = 1'b1; mine_map[1] = 1'b0;
        build_expected(COLS, TW, TH, 1, 1, mine_map, flag_map, step_map, reveal_all);
        request(0, 1, 1);
        capture(1000);
        n_cmp++;
        if (cap_q.size() !== 266 || first_diff() !== -1 || img[20][3] !== 7 || img[5][5] !== -1) begin
            n_bad++;
            $display("FAIL single1: got %0d plots, diff %0d, (20,3)=%0d, (5,5)=%0d, required 266 -1 7 -1",
                     cap_q.size(), first_diff(), img[20][3], img[5][5]);
        end
    endtask

    task automatic test_reveal_all();
        mine_map = 0; flag_map = 0; step_map = 0; reveal_all = 1'b1;
        mine_map[63] = 1'b1; mine_map[62] = 1'b1; flag_map[62] = 1'b1;
        build_expected(COLS, TW, TH, 0, N - 1, mine_map, flag_map, step_map, reveal_all);
        request(1, 0, 0);
        capture(20000);
        n_cmp++;
        if (cap_q.size() !== 17024 || first_diff() !== -1) begin
            n_bad++;
            $display("FAIL reveal_frame: got %0d plots first diff %0d, required 17024 plots diff -1",
                     cap_q.size(), first_diff());
        end
        n_cmp++;
        if (img[134][99] !== 5 || img[115][99] !== 2) begin
            n_bad++;
            $display("FAIL reveal_tiles: got tile63=%0d tile62=%0d, required 5 2", img[134][99], img[115][99]);
        end
        reveal_all = 1'b0;
    endtask

    task automatic test_random_tiles();
        int idx;
        for (int it = 0; it < 12; it++) begin
            rand_maps();
            idx = $urandom_range(0, N - 1);
            build_expected(COLS, TW, TH, idx, idx, mine_map, flag_map, step_map, reveal_all);
            request(0, 1, idx);
            capture(1000);
            n_cmp++;
            if (cap_q.size() !== 266 || done_at !== 268 || first_diff() !== -1) begin
                n_bad++;
                $display("FAIL rand_tile%0d: got %0d plots done %0d diff %0d, required 266 268 -1",
                         idx, cap_q.size(), done_at, first_diff());
            end
        end
    endtask

    task automatic test_busy_ignored();
        int stray;
        rand_maps();
        step_map[0] = 1'b0;
        build_expected(COLS, TW, TH, 0, N - 1, mine_map, flag_map, step_map, reveal_all);
        request(1, 0, 0);
        fork
            capture(20000);
            begin
                repeat (40) @(posedge clk);
                #1 go = 1'b1; go_tile = 1'b1; tile_idx = 6'd5; flag_map[0] = ~flag_map[0];
                @(posedge clk); #1 go = 1'b0; go_tile = 1'b0;
            end
        join
        n_cmp++;
        if (cap_q.size() !== 17024 || done_at !== 17026) begin
            n_bad++;
            $display("FAIL busy_count: got %0d plots done %0d, required 17024 done 17026", cap_q.size(), done_at);
        end
        n_cmp++;
        if (first_diff() !== -1) begin
            n_bad++;
            $display("FAIL busy_pixels: plot %0d got c%0d, required c%0d", first_diff(),
                     cap_q[first_diff()].c, exp_q[first_diff()].c);
        end
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || write_en) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL busy_not_queued: got %0d active cycles after done, required 0", stray);
        end
    endtask

    task automatic test_reset_mid_draw();
        int stray;
        rand_maps();
        request(1, 0, 0);
        repeat (100) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({x, y, color, write_en, busy} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_mid_draw: got x=%0d y=%0d c=%0d we=%b busy=%b, required all 0",
                     x, y, color, write_en, busy);
        end
        @(posedge clk); #1 resetn = 1'b1;
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy || write_en || done) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL reset_stays_idle: got %0d active cycles, required 0", stray);
        end
        rand_maps();
        build_expected(COLS, TW, TH, 0, N - 1, mine_map, flag_map, step_map, reveal_all);
        request(1, 1, 7);
        capture(20000);
        n_cmp++;
        if (cap_q.size() !== 17024 || done_at !== 17026 || first_diff() !== -1) begin
            n_bad++;
            $display("FAIL reset_redraw: got %0d plots done %0d diff %0d, required 17024 17026 -1",
                     cap_q.size(), done_at, first_diff());
        end
    endtask

    initial begin
        test_reset();
        test_small_full();
        test_flag_full();
        test_single_tile();
        test_reveal_all();
        test_random_tiles();
        test_busy_ignored();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
Parametrised tile-grid renderer for the minesweeper board. It scans a COLS x ROWS grid of TILE_W x TILE_H pixel tiles and emits one plot per clock (x, y, color, writeEn) to the 160x120 VGA adapter. Tile colour comes from the mine, flag and step maps. It supports full-board redraw and single-tile redraw, and sits between the game logic and the vga_adapter.

Parameters:
COLS, 8, tiles per row
ROWS, 8, tiles per column
TILE_W, 19, tile width in pixels, including a 1-pixel right grid line
TILE_H, 14, tile height in pixels, including a 1-pixel bottom grid line
ORIGIN_X, 0, screen x of the top-left board pixel
ORIGIN_Y, 0, screen y of the top-left board pixel
N, COLS*ROWS, tile count (derived, not overridden)
IDX_W, clog2(N), tile index width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  1  one-cycle request: full-board redraw
go_tile  in  1  one-cycle request: redraw tile tile_idx only
tile_idx  in  IDX_W  tile for go_tile, row-major (row*COLS+col)
reveal_all  in  1  game-over mode: show every mine
mineMap  in  N  1 = mine at tile index
flagMap  in  N  1 = flagged
stepMap  in  N  1 = uncovered
x  out  8  plot x
y  out  7  plot y
color  out  3  plot colour {R,G,B}
writeEn  out  1  plot strobe to the adapter
busy  out  1  draw in progress
done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (async, resetn=0): state IDLE. x=0, y=0, color=0, writeEn=0, busy=0, done=0. All counters and snapshots are cleared immediately, including mid-draw; no further plots are emitted.
- States: IDLE -> LATCH -> DRAW -> DONE -> IDLE.
- IDLE: go=1 -> LATCH, mode FULL, start tile 0, last tile N-1.
- IDLE: go_tile=1 -> LATCH, mode SINGLE, start = last = tile_idx.
- go and go_tile in the same cycle: FULL wins.
- tile_idx >= N with go_tile: request ignored, stays IDLE.
- LATCH (1 cycle): snapshot mineMap, flagMap, stepMap and reveal_all. Map changes during DRAW do not affect the frame. Pixel counters px=py=0; busy=1.
- DRAW: one pixel per cycle. writeEn=1 on every DRAW cycle. x, y and color are registered, so the first plot is valid in the cycle after LATCH.
  - x = ORIGIN_X + col*TILE_W + px; y = ORIGIN_Y + row*TILE_H + py; results are truncated to 8/7 bits.
  - Order: px fastest, then py, then tile index ascending.
  - At px=TILE_W-1: px wraps to 0 and py increments.
  - At py=TILE_H-1 with px=TILE_W-1: advance to the next tile, or go to DONE if at the last tile.
  - col and row are kept as separate counters; no divider.
- Colour per pixel, highest priority first:
  1. Grid line (px=TILE_W-1 or py=TILE_H-1): 3'b000.
  2. stepped & mine: 3'b100 (exploded).
  3. stepped & ~mine: 3'b111.
  4. flagged & ~stepped: 3'b010.
  5. reveal_all & mine & ~flagged: 3'b101.
  6. Otherwise covered: 3'b001.
- DONE (1 cycle): writeEn=0, done=1, busy=0 -> IDLE.
- go or go_tile while busy (LATCH/DRAW/DONE): ignored, not queued.
- Cycle counts:
  - FULL: N*TILE_W*TILE_H plots; done asserts exactly 2 + N*TILE_W*TILE_H cycles after the go sample edge.
  - SINGLE: TILE_W*TILE_H plots.
- Outside DRAW, writeEn=0. x, y and color hold their last value; they are don't-care to the adapter.

Test Plan:
- COLS=2, ROWS=2, TILE_W=3, TILE_H=2, all maps 0, pulse go -> 24 writeEn cycles. Pixel order (0,0),(1,0),(2,0),(0,1)..., then tile 1 starting at (3,0). Colour 3'b001 except grid pixels 3'b000. done pulses once, 26 cycles after the go edge.
- Defaults, flagMap[9]=1 (row 1, col 1), go -> pixel (19,14) colour 3'b010; (37,14) and (19,27) 3'b000. Total 17024 plots.
- Defaults, stepMap[0]=mineMap[0]=1, go_tile with tile_idx=0 -> exactly 266 plots, x 0..18, y 0..13. Interior colour 3'b100. Then stepMap[1]=1, mine 0, go_tile idx 1 -> interior 3'b111 at x 19..36.
- reveal_all=1, mineMap[63]=1, flagMap[62]=mineMap[62]=1, go -> tile 63 interior 3'b101, tile 62 interior 3'b010.
- During DRAW: pulse go and go_tile, and toggle flagMap[0] -> no restart, tile 0 colour unchanged from snapshot, plot count unchanged.
- resetn=0 for one cycle mid-DRAW -> writeEn, busy, x, y, color are 0 in that same cycle. After release the block stays IDLE until a new go; a new go draws a full frame correctly.
